// File: rtl/peg_solitaire_engine.sv
// Peg solitaire move engine: holds a cross-shaped board, executes jump/undo commands
// through an IDLE/EXEC/RESP handshake and keeps a circular undo history.
module peg_solitaire_engine #(
  parameter int BOARD_WIDTH = 7,
  parameter int ARM = 2,
  parameter int HIST_DEPTH = 8,
  localparam int CW = $clog2(BOARD_WIDTH),
  localparam int NW = $clog2(BOARD_WIDTH*BOARD_WIDTH+1),
  localparam int HCW = $clog2(HIST_DEPTH+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_undo,
  input  logic [CW-1:0]  piece_x,
  input  logic [CW-1:0]  piece_y,
  input  logic [1:0]     direction,
  output logic           rsp_valid,
  output logic           rsp_ok,
  output logic [NW-1:0]  piece_count,
  output logic [HCW-1:0] hist_count,
  output logic           game_over,
  output logic           game_won
);

  localparam int NCELL       = BOARD_WIDTH*BOARD_WIDTH;
  localparam int IW          = $clog2(NCELL);
  localparam int HPW         = $clog2(HIST_DEPTH);
  localparam int EW          = 2*CW+2;
  localparam int CENTRE      = (BOARD_WIDTH-1)/2;
  localparam int CENTRE_IDX  = CENTRE*BOARD_WIDTH + CENTRE;
  localparam int INIT_PIECES = NCELL - 4*ARM*ARM - 1;

  function automatic logic cell_exists(int x, int y);
    logic in_x;
    logic in_y;
    in_x = (x >= ARM) && (x <= BOARD_WIDTH-1-ARM);
    in_y = (y >= ARM) && (y <= BOARD_WIDTH-1-ARM);
    return (x >= 0) && (x < BOARD_WIDTH) && (y >= 0) && (y < BOARD_WIDTH) && (in_x || in_y);
  endfunction

  // Non-existent coordinates map to cell 0 so every board select stays in range.
  function automatic logic [IW-1:0] cell_idx(int x, int y);
    if (!cell_exists(x, y)) return '0;
    return IW'(y*BOARD_WIDTH + x);
  endfunction

  function automatic logic move_legal(logic [NCELL-1:0] b, int x, int y, int dx, int dy);
    if (!(cell_exists(x, y) && cell_exists(x+dx, y+dy) && cell_exists(x+2*dx, y+2*dy)))
      return 1'b0;
    return b[cell_idx(x, y)] && b[cell_idx(x+dx, y+dy)] && !b[cell_idx(x+2*dx, y+2*dy)];
  endfunction

  function automatic int dir_dx(logic [1:0] d);
    case (d)
      2'd0:    return -1;
      2'd1:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int dir_dy(logic [1:0] d);
    case (d)
      2'd2:    return -1;
      2'd3:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [NCELL-1:0] init_board();
    logic [NCELL-1:0] b;
    b = '0;
    for (int y = 0; y < BOARD_WIDTH; y++)
      for (int x = 0; x < BOARD_WIDTH; x++)
        if (cell_exists(x, y) && !(x == CENTRE && y == CENTRE))
          b[y*BOARD_WIDTH + x] = 1'b1;
    return b;
  endfunction

  localparam logic [NCELL-1:0] RESET_BOARD = init_board();

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             undo_reg;
  logic [CW-1:0]    x_reg;
  logic [CW-1:0]    y_reg;
  logic [1:0]       dir_reg;
  logic [NCELL-1:0] board_reg;
  logic [NCELL-1:0] board_next;
  logic [NW-1:0]    piece_count_reg;
  logic [HPW-1:0]   hist_ptr_reg;
  logic [HCW-1:0]   hist_count_reg;
  logic             ok_reg;
  logic             game_over_reg;
  logic             game_won_reg;
  logic [EW-1:0]    hist_mem [HIST_DEPTH];

  logic [EW-1:0]    hist_top;
  logic [CW-1:0]    src_x;
  logic [CW-1:0]    src_y;
  logic [1:0]       src_dir;
  logic [IW-1:0]    o_idx;
  logic [IW-1:0]    m_idx;
  logic [IW-1:0]    d_idx;
  logic             move_ok;
  logic             undo_ok;
  logic             exec_ok;
  logic [NCELL-1:0] cell_has_move;
  logic             accept;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_ok     = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_ok     = ok_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = (state_reg == IDLE) && cmd_valid;

  // An undo replays the newest history entry's path with the cell values inverted.
  always_comb begin
    hist_top = hist_mem[hist_ptr_reg - HPW'(1)];
    if (undo_reg) begin
      src_x   = hist_top[EW-1 -: CW];
      src_y   = hist_top[CW+1 -: CW];
      src_dir = hist_top[1:0];
    end else begin
      src_x   = x_reg;
      src_y   = y_reg;
      src_dir = dir_reg;
    end
  end

  always_comb begin
    int ox;
    int oy;
    int dx;
    int dy;
    ox      = int'(src_x);
    oy      = int'(src_y);
    dx      = dir_dx(src_dir);
    dy      = dir_dy(src_dir);
    o_idx   = cell_idx(ox, oy);
    m_idx   = cell_idx(ox+dx, oy+dy);
    d_idx   = cell_idx(ox+2*dx, oy+2*dy);
    move_ok = !undo_reg && move_legal(board_reg, ox, oy, dx, dy);
    undo_ok = undo_reg && (hist_count_reg != '0);
    exec_ok = move_ok || undo_ok;
    board_next = board_reg;
    if (exec_ok) begin
      board_next[o_idx] = undo_ok;
      board_next[m_idx] = undo_ok;
      board_next[d_idx] = move_ok;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCELL; gi++) begin : g_cell
      localparam int CX = gi % BOARD_WIDTH;
      localparam int CY = gi / BOARD_WIDTH;
      assign cell_has_move[gi] = move_legal(board_reg, CX, CY, -1, 0) ||
                                 move_legal(board_reg, CX, CY,  1, 0) ||
                                 move_legal(board_reg, CX, CY,  0, -1) ||
                                 move_legal(board_reg, CX, CY,  0, 1);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      undo_reg        <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      dir_reg         <= '0;
      board_reg       <= RESET_BOARD;
      piece_count_reg <= NW'(INIT_PIECES);
      hist_ptr_reg    <= '0;
      hist_count_reg  <= '0;
      ok_reg          <= 1'b0;
      game_over_reg   <= 1'b0;
      game_won_reg    <= 1'b0;
    end else begin
      game_over_reg <= ~|cell_has_move;
      game_won_reg  <= (piece_count_reg == NW'(1)) && board_reg[CENTRE_IDX];
      if (accept) begin
        undo_reg <= cmd_undo;
        x_reg    <= piece_x;
        y_reg    <= piece_y;
        dir_reg  <= direction;
      end
      if (state_reg == EXEC) begin
        ok_reg    <= exec_ok;
        board_reg <= board_next;
        if (move_ok) begin
          piece_count_reg <= piece_count_reg - NW'(1);
          hist_ptr_reg    <= hist_ptr_reg + HPW'(1);
          if (hist_count_reg != HCW'(HIST_DEPTH))
            hist_count_reg <= hist_count_reg + HCW'(1);
        end else if (undo_ok) begin
          piece_count_reg <= piece_count_reg + NW'(1);
          hist_ptr_reg    <= hist_ptr_reg - HPW'(1);
          hist_count_reg  <= hist_count_reg - HCW'(1);
        end
      end
    end
  end

  // When full, the write pointer already sits on the oldest entry, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (state_reg == EXEC && move_ok)
      hist_mem[hist_ptr_reg] <= {x_reg, y_reg, dir_reg};
  end

  assign piece_count = piece_count_reg;
  assign hist_count  = hist_count_reg;
  assign game_over   = game_over_reg;
  assign game_won    = game_won_reg;

endmodule

// File: tb/tb_peg_solitaire_engine.sv
// Randomised scoreboard bench for peg_solitaire_engine against a board/queue reference model.
module tb_peg_solitaire_engine;

  localparam int W   = 7;
  localparam int ARM = 2;
  localparam int HD  = 8;
  localparam int CW  = $clog2(W);
  localparam int NW  = $clog2(W*W+1);
  localparam int HCW = $clog2(HD+1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_undo = 1'b0;
  logic [CW-1:0]  piece_x = '0;
  logic [CW-1:0]  piece_y = '0;
  logic [1:0]     direction = '0;
  logic           rsp_valid;
  logic           rsp_ok;
  logic [NW-1:0]  piece_count;
  logic [HCW-1:0] hist_count;
  logic           game_over;
  logic           game_won;

  peg_solitaire_engine #(.BOARD_WIDTH(W), .ARM(ARM), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_undo(cmd_undo), .piece_x(piece_x), .piece_y(piece_y), .direction(direction),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .piece_count(piece_count),
    .hist_count(hist_count), .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit ok; int pc; int hc; bit over; bit won; int rsp_cyc; } exp_t;
  typedef struct { int x; int y; int d; } mv_t;

  exp_t sb[$];
  mv_t  hist[$];
  bit   mb [W][W];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic bit exists(int x, int y);
    if (x < 0 || y < 0 || x >= W || y >= W) return 0;
    return (x >= ARM && x < W-ARM) || (y >= ARM && y < W-ARM);
  endfunction

  function automatic int ddx(int d); return (d == 0) ? -1 : (d == 1) ? 1 : 0; endfunction
  function automatic int ddy(int d); return (d == 2) ? -1 : (d == 3) ? 1 : 0; endfunction

  function automatic bit legal(int x, int y, int d);
    int mx = x + ddx(d), my = y + ddy(d), tx = x + 2*ddx(d), ty = y + 2*ddy(d);
    if (!exists(x, y) || !exists(mx, my) || !exists(tx, ty)) return 0;
    return mb[y][x] && mb[my][mx] && !mb[ty][tx];
  endfunction

  function automatic void model_reset();
    for (int y = 0; y < W; y++)
      for (int x = 0; x < W; x++)
        mb[y][x] = exists(x, y) && !(x == (W-1)/2 && y == (W-1)/2);
    hist.delete();
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int y = 0; y < W; y++)
      for (int x = 0; x < W; x++) n += int'(mb[y][x]);
    return n;
  endfunction

  function automatic bit model_over();
    for (int y = 0; y < W; y++)
      for (int x = 0; x < W; x++)
        for (int d = 0; d < 4; d++)
          if (legal(x, y, d)) return 0;
    return 1;
  endfunction

  function automatic bit model_apply(bit u, int x, int y, int d);
    mv_t m;
    if (u) begin
      if (hist.size() == 0) return 0;
      m = hist.pop_back();
      mb[m.y][m.x] = 1;
      mb[m.y+ddy(m.d)][m.x+ddx(m.d)] = 1;
      mb[m.y+2*ddy(m.d)][m.x+2*ddx(m.d)] = 0;
      return 1;
    end
    if (!legal(x, y, d)) return 0;
    mb[y][x] = 0;
    mb[y+ddy(d)][x+ddx(d)] = 0;
    mb[y+2*ddy(d)][x+2*ddx(d)] = 1;
    m.x = x; m.y = y; m.d = d;
    hist.push_back(m);
    if (hist.size() > HD) void'(hist.pop_front());
    return 1;
  endfunction

  // ---------------- monitor ----------------
  bit   flags_pending = 0;
  exp_t last_exp;

  always @(negedge clk) begin
    exp_t e;
    if (flags_pending) begin
      chk("game_over", int'(game_over), int'(last_exp.over));
      chk("game_won", int'(game_won), int'(last_exp.won));
      flags_pending = 0;
    end
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_ok", int'(rsp_ok), int'(e.ok));
        chk("piece_count", int'(piece_count), e.pc);
        chk("hist_count", int'(hist_count), e.hc);
        chk("rsp_latency", cyc, e.rsp_cyc);
        $display("rsp: ok=%0d pieces=%0d hist=%0d", rsp_ok, piece_count, hist_count);
        last_exp = e;
        flags_pending = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit u, input int x, input int y, input int d, output int waited);
    exp_t e;
    cmd_undo  = u;
    piece_x   = CW'(x);
    piece_y   = CW'(y);
    direction = 2'(d);
    cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    e.rsp_cyc = cyc + 2;
    e.ok      = model_apply(u, x, y, d);
    e.pc      = model_count();
    e.hc      = hist.size();
    e.over    = model_over();
    e.won     = (model_count() == 1) && mb[(W-1)/2][(W-1)/2];
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    model_reset();
    sb.delete();
    flags_pending = 0;
    #1;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pieces", int'(piece_count), W*W - 4*ARM*ARM - 1);
    chk("rst_hist", int'(hist_count), 0);
    chk("rst_rsp_ok", int'(rsp_ok), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_game_won", int'(game_won), 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic random_legal(output bit found, output mv_t m);
    mv_t cand[$];
    mv_t c;
    for (int y = 0; y < W; y++)
      for (int x = 0; x < W; x++)
        for (int d = 0; d < 4; d++)
          if (legal(x, y, d)) begin
            c.x = x; c.y = y; c.d = d;
            cand.push_back(c);
          end
    found = cand.size() > 0;
    if (found) m = cand[$urandom_range(0, cand.size()-1)];
    else m = c;
  endtask

  initial begin
    int  w;
    int  rc;
    bit  f;
    mv_t m;

    do_reset();

    // reference game opening, illegal move and undo sequence
    send(0, 3, 1, 3, w);
    drain();
    do_reset();
    send(0, 0, 0, 1, w);
    send(0, 3, 1, 3, w);
    send(1, 0, 0, 0, w);
    send(1, 0, 0, 0, w);
    drain();

    // back-to-back with cmd_valid held high
    do_reset();
    send(0, 3, 1, 3, w);
    send(0, 5, 2, 0, w);
    chk("ready_low_cycles", w, 2);
    drain();

    // fill history beyond its depth, then unwind it
    do_reset();
    for (int i = 0; i < HD + 2; i++) begin
      random_legal(f, m);
      if (f) send(0, m.x, m.y, m.d, w);
    end
    for (int i = 0; i < HD + 2; i++) send(1, 0, 0, 0, w);
    drain();

    // random mixed traffic
    for (int i = 0; i < 300; i++) begin
      if (i % 100 == 99) begin
        drain();
        do_reset();
      end
      case ($urandom_range(0, 9))
        0, 1, 2: send(1, 0, 0, 0, w);
        3, 4, 5, 6: begin
          random_legal(f, m);
          if (f) send(0, m.x, m.y, m.d, w);
          else send(1, 0, 0, 0, w);
        end
        default: send(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), w);
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    // reset while a command is in EXEC
    do_reset();
    cmd_undo = 1'b0; piece_x = 3'd3; piece_y = 3'd1; direction = 2'd3;
    cmd_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", int'(cmd_ready), 1);
    chk("post_rst_pieces", int'(piece_count), 32);
    rc = 0;
    repeat (4) begin
      @(negedge clk);
      rc += int'(rsp_valid);
    end
    chk("abandoned_rsp", rc, 0);
    send(0, 3, 1, 3, w);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/peg_solitaire_engine.md
PEG_SOLITAIRE_ENGINE -- requirements
Module: peg_solitaire_engine

Interface
REQ-001 Parameter BOARD_WIDTH, default 7: board edge length; odd, 5..9.
REQ-002 Parameter ARM, default 2: width of the empty dead corner squares; 1 <= ARM <= (BOARD_WIDTH-1)/2.
REQ-003 Parameter HIST_DEPTH, default 8: undo history depth, in entries; a power of two, >= 2.
REQ-004 Derived widths: CW = $clog2(BOARD_WIDTH) and NW = $clog2(BOARD_WIDTH*BOARD_WIDTH+1).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cmd_valid  input  1  command present.
REQ-008 cmd_ready  output  1  engine can accept a command.
REQ-009 cmd_undo  input  1  1 = undo the last move, 0 = make a move.
REQ-010 piece_x, piece_y  input  CW each  coordinates of the jumping peg; y increases downward.
REQ-011 direction  input  2  jump direction: LEFT=0, RIGHT=1, UP=2, DOWN=3.
REQ-012 rsp_valid  output  1  one-cycle result pulse.
REQ-013 rsp_ok  output  1  command executed; qualified by rsp_valid.
REQ-014 piece_count  output  NW  pegs currently on the board.
REQ-015 hist_count  output  $clog2(HIST_DEPTH+1)  number of undoable moves.
REQ-016 game_over  output  1  registered; no legal move exists anywhere on the board.
REQ-017 game_won  output  1  registered; piece_count==1 and the centre cell is occupied.

Function
REQ-018 Cell (x,y) SHALL exist when x or y lies in [ARM, BOARD_WIDTH-1-ARM]; non-existent cells SHALL always read 0.
REQ-019 Handshake: a command SHALL be accepted on a clock edge with cmd_valid && cmd_ready; all command fields SHALL be captured at that edge.
REQ-020 FSM states: IDLE (cmd_ready=1), EXEC (cmd_ready=0), RESP (cmd_ready=0, rsp_valid=1).
- IDLE -> EXEC on accept; EXEC -> RESP always; RESP -> IDLE always.
- Throughput: one command per 3 cycles.
REQ-021 EXEC SHALL evaluate the captured command against the current board.
- Board, piece_count and history updates SHALL take effect at the EXEC->RESP edge.
- rsp_ok SHALL be valid during RESP.
REQ-022 A move SHALL be legal when all three cells on its path exist and are in bounds, the origin and middle cells hold pegs, and the destination is empty.
REQ-023 Legal move: origin and middle cleared, destination set, piece_count decremented, {x,y,dir} pushed to history, rsp_ok=1.
REQ-024 Illegal move, including an out-of-range coordinate: no state change, rsp_ok=0.
REQ-025 History SHALL be a circular LIFO of HIST_DEPTH entries.
- A push when full SHALL overwrite the oldest entry; hist_count saturates at HIST_DEPTH.
REQ-026 Undo with hist_count>0: pop the newest entry, set origin and middle, clear destination, increment piece_count, rsp_ok=1.
REQ-027 Undo with hist_count==0: no state change, rsp_ok=0.
REQ-028 cmd_valid in EXEC or RESP SHALL be ignored; the command SHALL be held by the sender until accepted.
REQ-029 game_over and game_won SHALL be recomputed from the board every cycle and registered, lagging the board by one cycle.

Reset
REQ-030 rst_n low SHALL immediately set the FSM to IDLE and the board to all existing cells occupied except the centre ((BOARD_WIDTH-1)/2 in both axes).
- piece_count = BOARD_WIDTH^2 - 4*ARM^2 - 1 (32 at defaults).
- hist_count=0, rsp_valid=0, rsp_ok=0, game_over=0, game_won=0.
REQ-031 Reset asserted in EXEC or RESP SHALL abandon the command: no response pulse, board restored to its reset value.

Verification
REQ-032 Defaults, reset then move (3,1) DOWN: rsp_valid at accept+2 with rsp_ok=1; piece_count=31; (3,1),(3,2) empty; (3,3) full; hist_count=1.
REQ-033 Move (0,0) RIGHT from reset: rsp_ok=0; piece_count=32; board unchanged.
REQ-034 Undo after REQ-032: rsp_ok=1; board equals reset value; piece_count=32; hist_count=0. A second undo: rsp_ok=0.
REQ-035 HIST_DEPTH=2: three legal moves then three undos: undos respond 1,1,0; piece_count 29->30->31->31.
REQ-036 Defaults, cmd_valid held continuously over two commands: cmd_ready low for exactly 2 cycles after each accept; second command accepted on the cycle after RESP.
REQ-037 rst_n pulsed low during EXEC: no rsp_valid; piece_count=32; cmd_ready=1 on the first edge after release.
